// File: rtl/rr_arbiter_4_if.sv
// Bus between four requesters and the rr_arbiter_4 round-robin arbiter.
// Requesters drive req/done. The arbiter returns a registered one-hot grant, its index,
// a valid flag, a forced-release pulse and its FSM state for observation.
interface rr_arbiter_4_if;
  // Handshake: req[i] is a level. Requester i owns the resource while gnt[i]=1, and gnt
  // is updated only at a clock edge. Ownership ends at the first edge that samples done=1
  // or req[owner]=0. After that edge gnt stays 0 for exactly one dead cycle.
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic [1:0] dbg_state;

  modport master (output req, output done,
                  input gnt, input gnt_idx, input gnt_vld, input timeout, input dbg_state);
  modport slave  (input req, input done,
                  output gnt, output gnt_idx, output gnt_vld, output timeout, output dbg_state);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a registered grant and a one-cycle turnaround between owners.
// The optional forced release after MAX_HOLD grant cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic          clk,
  input  logic          rst,
  rr_arbiter_4_if.slave bus
);

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        gnt_q, gnt_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [1:0]        last, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              tmo_q, tmo_nxt;
  logic [1:0]        win, cand;
  logic              win_vld;
  logic              rel, hold_lim, tmo_hit;

  // Search last+4 down to last+1, so the candidate closest after last wins.
  always_comb begin
    win_vld = 1'b0;
    win     = 2'd0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  assign rel      = bus.done || !bus.req[idx];
  assign hold_lim = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign tmo_hit  = TIMEOUT_ON && hold_lim && !rel;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    idx_nxt   = idx;
    last_nxt  = last;
    hold_nxt  = hold_cnt;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE, RELEASE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win;
          idx_nxt   = win;
          last_nxt  = win;
          hold_nxt  = '0;
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
        end
      end
      GRANT: begin
        if (rel || tmo_hit) begin
          state_nxt = RELEASE;
          gnt_nxt   = 4'b0000;
          tmo_nxt   = tmo_hit;
        end else if (hold_cnt != {HOLD_W{1'b1}}) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= 4'b0000;
      idx      <= 2'd0;
      last     <= 2'd3;
      hold_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      idx      <= idx_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      tmo_q    <= tmo_nxt;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx;
  assign bus.gnt_vld   = |gnt_q;
  assign bus.timeout   = tmo_q;
  assign bus.dbg_state = state;

endmodule
